// File: rtl/i2s_audio_tx.sv
`timescale 1ns/1ps
// I2S transmitter for the Pmod DAC: serializes 16-bit L/R pairs MSB first with
// the standard one-sck delay after each lrck edge. All pins come from register bits.
module i2s_audio_tx #(
  parameter int unsigned BITS          = 16,
  parameter int unsigned SCK_DIV_LOG2  = 4,
  parameter int unsigned MCLK_DIV_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            mute,
  input  logic [BITS-1:0] audio_in_left,
  input  logic [BITS-1:0] audio_in_right,
  output logic            sample_req,
  output logic            busy,
  output logic            audio_mclk,
  output logic            audio_lrck,
  output logic            audio_sck,
  output logic            audio_sdin
);

  localparam int unsigned FRAME_W = 2 * BITS;
  localparam int unsigned CNT_W   = SCK_DIV_LOG2 + $clog2(FRAME_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_div_cnt;
  logic [FRAME_W-1:0]   r_shift;
  logic                 r_sdin;
  logic                 r_sample_req;

  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [FRAME_W-1:0]   w_next_pair;

  assign w_bit_end   = &r_div_cnt[SCK_DIV_LOG2-1:0];
  assign w_frame_end = &r_div_cnt;
  assign w_next_pair = mute ? '0 : {audio_in_left, audio_in_right};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_shift      <= '0;
      r_sdin       <= 1'b0;
      r_sample_req <= 1'b0;
    end else begin
      r_sample_req <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_div_cnt <= '0;
          r_sdin    <= 1'b0;
          if (enable) begin
            r_shift      <= w_next_pair;
            r_sample_req <= 1'b1;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          r_div_cnt <= r_div_cnt + CNT_W'(1);
          if (w_bit_end) begin
            r_sdin  <= r_shift[FRAME_W-1];
            r_shift <= r_shift << 1;
          end
          // Last shift of the frame and the next latch share this edge; the latch wins r_shift.
          if (w_frame_end) begin
            if (enable) begin
              r_shift      <= w_next_pair;
              r_sample_req <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_div_cnt <= r_div_cnt + CNT_W'(1);
          if (w_bit_end) begin
            r_div_cnt <= '0;
            r_sdin    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_req = r_sample_req;
  assign busy       = (r_state != S_IDLE);
  assign audio_mclk = r_div_cnt[MCLK_DIV_LOG2-1];
  assign audio_sck  = r_div_cnt[SCK_DIV_LOG2-1];
  assign audio_lrck = r_div_cnt[CNT_W-1];
  assign audio_sdin = r_sdin;

endmodule

// File: tb/tb_i2s_audio_tx.sv
`timescale 1ns/1ps
// Directed bench for i2s_audio_tx: expected serial bits are queued per latched
// pair and checked by an independent monitor on every sck rising edge.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        rst, enable, mute;
  logic [15:0] audio_in_left, audio_in_right;
  logic        sample_req, busy, audio_mclk, audio_lrck, audio_sck, audio_sdin;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit prev_r0;

  logic [15:0] vl [0:7];
  logic [15:0] vr [0:7];
  logic        vm [0:7];

  i2s_audio_tx #(.BITS(16), .SCK_DIV_LOG2(4), .MCLK_DIV_LOG2(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mute(mute),
    .audio_in_left(audio_in_left), .audio_in_right(audio_in_right),
    .sample_req(sample_req), .busy(busy), .audio_mclk(audio_mclk),
    .audio_lrck(audio_lrck), .audio_sck(audio_sck), .audio_sdin(audio_sdin)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input int i);
    audio_in_left  = vl[i];
    audio_in_right = vr[i];
    mute           = vm[i];
  endtask

  // Slot 0 carries the previous frame's R[0]; slots 1..31 are L[15:0], R[15:1].
  task automatic push_frame(input int i);
    logic [31:0] w;
    w = vm[i] ? 32'h0 : {vl[i], vr[i]};
    exp_q.push_back(prev_r0);
    for (int b = 31; b >= 1; b--) exp_q.push_back(w[b]);
    prev_r0 = w[0];
  endtask

  function automatic logic [5:0] pins();
    return {sample_req, busy, audio_mclk, audio_lrck, audio_sck, audio_sdin};
  endfunction

  task automatic wait_req(input bit toggle, output int cyc);
    int k;
    bit bad;
    k = 0; bad = 0; cyc = -1;
    while (k < 600 && cyc < 0) begin
      @(negedge clk);
      k++;
      if (toggle && k == 200) enable = 1'b0;
      if (toggle && k == 300) enable = 1'b1;
      if (audio_mclk !== k[1] || audio_sck !== k[3] || audio_lrck !== k[8]) bad = 1;
      if (sample_req === 1'b1) cyc = k;
    end
    chk("pin_phase", {31'd0, bad}, 32'd0);
    chk("req_spacing", cyc, 32'd512);
  endtask

  // Monitor: pops one expected bit per sck rising edge.
  initial begin
    logic sck_d;
    bit   e;
    sck_d = 1'b0;
    forever begin
      @(negedge clk);
      if (audio_sck === 1'b1 && sck_d === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sdin_extra actual=%0b required=no_sck_edge", audio_sdin);
        end else begin
          e = exp_q.pop_front();
          if (audio_sdin !== e) begin
            errors++;
            $display("FAIL sdin_bit actual=%0b required=%0b", audio_sdin, e);
          end
        end
      end
      sck_d = audio_sck;
    end
  end

  task automatic drain_and_check(input int start_k, input string tag);
    bit extra_req, sdin_bad, busy_bad;
    logic r0;
    extra_req = 0; sdin_bad = 0; busy_bad = 0;
    r0 = prev_r0;
    exp_q.push_back(prev_r0);
    prev_r0 = 1'b0;
    for (int k = start_k + 1; k <= 560; k++) begin
      @(negedge clk);
      if (sample_req !== 1'b0) extra_req = 1;
      if (k >= 512 && k <= 527 && (audio_sdin !== r0 || audio_lrck !== 1'b0)) sdin_bad = 1;
      if (k <= 527 && busy !== 1'b1) busy_bad = 1;
      if (k >= 528 && (pins() !== 6'b0)) busy_bad = 1;
    end
    chk({tag, "_no_req"}, {31'd0, extra_req}, 32'd0);
    chk({tag, "_r0_hold"}, {31'd0, sdin_bad}, 32'd0);
    chk({tag, "_busy_pins"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  bad;
    vl[0] = 16'hA5C3; vr[0] = 16'h0F01; vm[0] = 1'b0;
    vl[1] = 16'h1234; vr[1] = 16'h8001; vm[1] = 1'b0;
    vl[2] = 16'hFFFF; vr[2] = 16'hFFFF; vm[2] = 1'b1;
    vl[3] = 16'h7E5A; vr[3] = 16'hC3A4; vm[3] = 1'b0;
    vl[4] = 16'h0001; vr[4] = 16'h8001; vm[4] = 1'b0;
    vl[5] = 16'h8000; vr[5] = 16'h4003; vm[5] = 1'b0;
    vl[6] = 16'h5555; vr[6] = 16'hAAAA; vm[6] = 1'b0;
    vl[7] = 16'hF00F; vr[7] = 16'h0FF1; vm[7] = 1'b0;

    rst = 1'b1; enable = 1'b0; mute = 1'b0;
    audio_in_left = '0; audio_in_right = '0;
    prev_r0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_pins", {26'd0, pins()}, 32'd0);
    rst = 1'b0;

    apply(0);
    enable = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, sample_req}, 32'd1);
    chk("busy_run", {31'd0, busy}, 32'd1);
    push_frame(0);
    apply(1);

    for (int i = 1; i <= 4; i++) begin
      wait_req(i == 2, cyc);
      push_frame(i);
      if (i < 4) apply(i + 1);
    end

    repeat (100) @(negedge clk);
    enable = 1'b0;
    drain_and_check(100, "drain1");

    apply(5);
    enable = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, sample_req}, 32'd1);
    push_frame(5);
    apply(6);
    wait_req(1'b0, cyc);
    push_frame(6);
    apply(7);

    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_pins", {26'd0, pins()}, 32'd0);
    exp_q.delete();
    prev_r0 = 1'b0;
    rst = 1'b0;
    enable = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (pins() !== 6'b0) bad = 1;
    end
    chk("post_reset_quiet", {31'd0, bad}, 32'd0);

    enable = 1'b1;
    @(negedge clk);
    chk("reenable_req", {31'd0, sample_req}, 32'd1);
    push_frame(7);
    enable = 1'b0;
    drain_and_check(0, "drain2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
Consumer end of the audio sample path. Takes 16-bit signed left/right samples from the tone/AM generators and serializes them to the Pmod I2S DAC as mclk/lrck/sck/sdin in standard I2S format (MSB first, one-sck delay after each lrck edge). Sits between the audio mixer and the top-level Pmod pins. Requests each new sample pair with a one-cycle strobe.

Parameters:
- BITS, 16, sample width per channel; fixed frame of 2×BITS slots.
- SCK_DIV_LOG2, 4, sck period = 2^SCK_DIV_LOG2 clk (16 clk → 6.25 MHz at 100 MHz).
- MCLK_DIV_LOG2, 2, mclk period = 2^MCLK_DIV_LOG2 clk (25 MHz at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = stream frames.
- mute  in  1  sampled with each sample pair; 1 = transmit zeros for that frame.
- audio_in_left  in  16  signed left sample.
- audio_in_right  in  16  signed right sample.
- sample_req  out  1  one-clk pulse: pair just latched, producer may update.
- busy  out  1  1 when state != IDLE.
- audio_mclk  out  1  master clock.
- audio_lrck  out  1  0 = left, 1 = right.
- audio_sck  out  1  bit clock.
- audio_sdin  out  1  serial data.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; div_cnt=0; shift_reg=0; all outputs 0. Applies mid-frame: pins go 0 on the next cycle; no partial frame resumes.
- div_cnt: 9-bit counter, 0..511, one frame = 512 clk. Derived outputs: audio_mclk=div_cnt[1], audio_sck=div_cnt[3], audio_lrck=div_cnt[8]. Slot s=div_cnt[8:4]. All are register bits, so there are no glitches.
- Latch: shift_reg[31:0] <= mute ? 0 : {audio_in_left, audio_in_right}. sample_req=1 in the cycle after each latch, for exactly 1 clk.
- IDLE: div_cnt held at 0; sdin=0.
  - If enable=1: latch, div_cnt=0, go RUN.
- RUN: div_cnt increments each clk, wrapping 511→0.
  - On every transition where div_cnt[3:0]==15 (sck falling edge): sdin <= shift_reg[31]; shift_reg <<= 1.
  - At div_cnt==511: the shift and the latch of the next pair happen in the same cycle. sdin gets the old R[0]; shift_reg gets the new frame.
  - Resulting sequence per frame:
    - slot 0: previous R[0], or 0 after IDLE.
    - slots 1–16: L[15]..L[0] (slot 16 has lrck=1).
    - slots 17–31: R[15]..R[1].
- enable=0 during RUN: takes effect only when div_cnt==511. At that edge:
  - perform the shift (sdin=R[0]);
  - do not latch and do not pulse sample_req;
  - go DRAIN with div_cnt=0.
  - enable=0 at any other time is ignored until the boundary.
- DRAIN: div_cnt counts 0..15 with sdin held at R[0] and lrck=0. At div_cnt==15: go IDLE (div_cnt=0, sdin=0). enable is ignored in DRAIN; if enable=1 in IDLE on the next cycle, restart normally.
- enable=1 throughout: sample_req period is exactly 512 clk, with no gaps between frames.
- Arithmetic: samples are passed bit-exact; no sign handling or saturation.

Test Plan:
- Reset, then enable=1 with L=16'hA5C3, R=16'h0F01:
  - sample_req pulses at cycle 1 after latch;
  - sdin sampled on sck rising edges reads slot0=0, then A5C3 MSB-first (slots 1–16), then 0F0 (slots 17–31 = R[15:1]);
  - next frame slot 0 = 1.
- Continuous streaming for 4 frames with a new pair on each sample_req: sample_req spacing = 512 clk; lrck toggles every 256 clk; mclk period 4 clk; sck period 16 clk.
- mute=1 at a latch with L=R=16'hFFFF: that frame's slots 1–31 are 0; the following unmuted frame carries data.
- Drop enable at div_cnt=100: the frame completes, R[0] is held for 16 clk in DRAIN with no extra sample_req, then busy=0 and all pins 0. Reassert enable: a new frame starts with slot 0=0.
- Assert rst at div_cnt=300 mid-frame: the next cycle shows all outputs 0 and busy=0; no sample_req until enable is reapplied.
- Toggle enable 1→0→1 within one frame: no effect on the stream (sampled only at div_cnt==511).
